// File: rtl/rpu_dispatch_pkg.sv
// Shared types and helpers for the RPU task dispatcher.
// task_t and IDLE_DATA cover the default widths only; the top module builds its own entry struct from its parameters.
package rpu_dispatch_pkg;

  localparam int unsigned PTW_D      = 16;
  localparam int unsigned MTW_D      = 0;
  localparam int unsigned TREE_NUM_D = 4;
  localparam int unsigned TNB_D      = $clog2(TREE_NUM_D);
  localparam int unsigned DW_D       = MTW_D + PTW_D;

  typedef enum logic [1:0] {
    OP_NOP     = 2'b00,
    OP_PUSH    = 2'b01,
    OP_POP     = 2'b10,
    OP_REPLACE = 2'b11
  } op_e;

  typedef struct packed {
    op_e               op;
    logic [TNB_D-1:0]  tree_id;
    logic [DW_D-1:0]   data;
  } task_t;

  localparam logic [DW_D-1:0] IDLE_DATA = '1;

  // Injection slot of a tree; level is a power of two.
  function automatic int unsigned slot_of(input int unsigned tree_id, input int unsigned level);
    return tree_id & (level - 1);
  endfunction

endpackage

// File: rtl/rpu_task_dispatch_queue.sv
// Per-port synchronous FIFO with a head-visible read port and occupancy count.
module task_queue #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned W     = 18
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic [W-1:0]           wr_data,
  input  logic                   rd_en,
  output logic [W-1:0]           head_c,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full_c,
  output logic                   empty_c
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_wr;
  logic          do_rd;

  assign full_c  = (count == CW'(DEPTH));
  assign empty_c = (count == '0);
  assign head_c  = mem[rd_ptr];
  assign do_wr   = wr_en & ~full_c;
  assign do_rd   = rd_en & ~empty_c;

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + AW'(1);
      if (do_rd) rd_ptr <= rd_ptr + AW'(1);
      case ({do_wr, do_rd})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/rpu_task_dispatch.sv
// Per-port command queues dispatched onto LEVEL RPU injection slots,
// one arbiter per slot, held off while ring traffic owns the slot.
module rpu_task_dispatch
  import rpu_dispatch_pkg::*;
#(
  parameter int unsigned PTW      = 16,
  parameter int unsigned MTW      = 0,
  parameter int unsigned TREE_NUM = 4,
  parameter int unsigned LEVEL    = 4,
  parameter int unsigned PORTS    = 4,
  parameter int unsigned DEPTH    = 8,
  parameter int unsigned ARB_MODE = 0,
  localparam int unsigned TNB     = (TREE_NUM > 1) ? $clog2(TREE_NUM) : 1,
  localparam int unsigned DW      = MTW + PTW,
  localparam int unsigned CW      = $clog2(DEPTH) + 1
) (
  input  logic                 i_clk,
  input  logic                 i_arst,
  input  logic [PORTS-1:0]     i_valid,
  output logic [PORTS-1:0]     o_ready,
  input  logic [2*PORTS-1:0]   i_op,
  input  logic [TNB*PORTS-1:0] i_tree_id,
  input  logic [DW*PORTS-1:0]  i_data,
  input  logic [LEVEL-1:0]     i_slot_busy,
  output logic [LEVEL-1:0]     o_rpu_push,
  output logic [LEVEL-1:0]     o_rpu_pop,
  output logic [TNB*LEVEL-1:0] o_rpu_tree_id,
  output logic [DW*LEVEL-1:0]  o_rpu_data,
  output logic [CW*PORTS-1:0]  o_fifo_count
);

  localparam int unsigned PW = (PORTS > 1) ? $clog2(PORTS) : 1;
  localparam int unsigned EW = 2 + TNB + DW;

  typedef struct packed {
    op_e            op;
    logic [TNB-1:0] tree_id;
    logic [DW-1:0]  data;
  } entry_t;

  entry_t           head     [PORTS];
  logic [PORTS-1:0] empty;
  logic [PORTS-1:0] full;
  logic [PORTS-1:0] deq;
  logic [PORTS-1:0] phase;
  logic [PORTS-1:0] granted;
  logic [LEVEL-1:0] win_valid;
  logic [PW-1:0]    win_port [LEVEL];

  for (genvar p = 0; p < PORTS; p++) begin : g_port
    logic [EW-1:0] head_raw;
    logic          enq;
    logic          phase_q;

    // Nop commands are accepted but never stored.
    assign enq        = i_valid[p] & ~full[p] & (i_op[2*p +: 2] != OP_NOP);
    assign o_ready[p] = ~full[p];
    assign head[p]    = entry_t'(head_raw);
    assign phase[p]   = phase_q;
    assign deq[p]     = granted[p] & ((head[p].op != OP_REPLACE) | phase_q);

    task_queue #(.DEPTH(DEPTH), .W(EW)) u_queue (
      .clk     (i_clk),
      .rst     (i_arst),
      .wr_en   (enq),
      .wr_data ({i_op[2*p +: 2], i_tree_id[TNB*p +: TNB], i_data[DW*p +: DW]}),
      .rd_en   (deq[p]),
      .head_c  (head_raw),
      .count   (o_fifo_count[CW*p +: CW]),
      .full_c  (full[p]),
      .empty_c (empty[p])
    );

    // Replace: phase 0 issues the pop and keeps the head, phase 1 issues the push.
    always_ff @(posedge i_clk or posedge i_arst) begin
      if (i_arst)                                    phase_q <= 1'b0;
      else if (granted[p] && head[p].op == OP_REPLACE) phase_q <= ~phase_q;
    end
  end

  always_comb begin
    granted = '0;
    for (int r = 0; r < LEVEL; r++) begin
      if (win_valid[r]) granted[win_port[r]] = 1'b1;
    end
  end

  for (genvar r = 0; r < LEVEL; r++) begin : g_slot
    logic [PORTS-1:0] cand;
    logic [PW-1:0]    idx;
    logic [PW-1:0]    rr_ptr;
    logic             wv;
    logic [PW-1:0]    wp;
    logic             push_q;
    logic             pop_q;
    logic [TNB-1:0]   tree_q;
    logic [DW-1:0]    data_q;

    always_comb begin
      cand = '0;
      for (int p = 0; p < PORTS; p++) begin
        cand[p] = ~empty[p] && (slot_of(32'(head[p].tree_id), LEVEL) == r);
      end
    end

    // Descending scan so the lowest offset from the search start wins.
    always_comb begin
      wv  = 1'b0;
      wp  = '0;
      idx = '0;
      if (!i_slot_busy[r]) begin
        for (int k = PORTS - 1; k >= 0; k--) begin
          idx = (ARB_MODE == 1) ? PW'(k) : PW'((32'(rr_ptr) + 32'(k)) % PORTS);
          if (cand[idx]) begin
            wv = 1'b1;
            wp = idx;
          end
        end
      end
    end

    assign win_valid[r] = wv;
    assign win_port[r]  = wp;

    always_ff @(posedge i_clk or posedge i_arst) begin
      if (i_arst)  rr_ptr <= '0;
      else if (wv) rr_ptr <= (32'(wp) == PORTS - 1) ? '0 : wp + PW'(1);
    end

    always_ff @(posedge i_clk or posedge i_arst) begin
      if (i_arst) begin
        push_q <= 1'b0;
        pop_q  <= 1'b0;
        tree_q <= '0;
        data_q <= '1;
      end else begin
        push_q <= 1'b0;
        pop_q  <= 1'b0;
        tree_q <= '0;
        data_q <= '1;
        if (wv) begin
          tree_q <= head[wp].tree_id;
          case (head[wp].op)
            OP_PUSH: begin
              push_q <= 1'b1;
              data_q <= head[wp].data;
            end
            OP_POP: pop_q <= 1'b1;
            OP_REPLACE: begin
              if (phase[wp]) begin
                push_q <= 1'b1;
                data_q <= head[wp].data;
              end else begin
                pop_q  <= 1'b1;
              end
            end
            default: ;
          endcase
        end
      end
    end

    assign o_rpu_push[r]               = push_q;
    assign o_rpu_pop[r]                = pop_q;
    assign o_rpu_tree_id[TNB*r +: TNB] = tree_q;
    assign o_rpu_data[DW*r +: DW]      = data_q;
  end

endmodule

// File: tb/tb_rpu_task_dispatch.sv
// Bench for rpu_task_dispatch: round-robin and fixed-priority instances,
// per-slot scoreboard with exact due cycles, plus directed corner cases.
module tb_rpu_task_dispatch;

  localparam int unsigned CW = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;

  logic [3:0]  valid, f_valid, ready, f_ready, busy, f_busy;
  logic [7:0]  op, f_op;
  logic [11:0] tree, f_tree, rtree, f_rtree;
  logic [63:0] data, f_data, rdata, f_rdata;
  logic [3:0]  push, pop, f_push, f_pop;
  logic [15:0] count, f_count;

  typedef struct {
    logic        push;
    logic        pop;
    logic [2:0]  tree;
    logic [15:0] data;
    int          due;
  } exp_t;

  exp_t sb [8][$];

  typedef struct {
    int          port;
    logic [1:0]  op;
    logic [2:0]  tree;
    logic [15:0] data;
    int          e_slot;
    int          e_n;
    logic        e_push1;
    logic        e_pop1;
    logic [15:0] e_d1;
    logic [15:0] e_d2;
    int          e_cnt;
  } vec_t;

  rpu_task_dispatch #(.PTW(16), .MTW(0), .TREE_NUM(8), .LEVEL(4), .PORTS(4), .DEPTH(8), .ARB_MODE(0)) dut (
    .i_clk(clk), .i_arst(rst), .i_valid(valid), .o_ready(ready), .i_op(op), .i_tree_id(tree),
    .i_data(data), .i_slot_busy(busy), .o_rpu_push(push), .o_rpu_pop(pop),
    .o_rpu_tree_id(rtree), .o_rpu_data(rdata), .o_fifo_count(count)
  );

  rpu_task_dispatch #(.PTW(16), .MTW(0), .TREE_NUM(8), .LEVEL(4), .PORTS(4), .DEPTH(8), .ARB_MODE(1)) dut_fp (
    .i_clk(clk), .i_arst(rst), .i_valid(f_valid), .o_ready(f_ready), .i_op(f_op), .i_tree_id(f_tree),
    .i_data(f_data), .i_slot_busy(f_busy), .o_rpu_push(f_push), .o_rpu_pop(f_pop),
    .o_rpu_tree_id(f_rtree), .o_rpu_data(f_rdata), .o_fifo_count(f_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_cmds();
    valid = '0; op = '0; tree = '0; data = '0;
    f_valid = '0; f_op = '0; f_tree = '0; f_data = '0;
  endtask

  task automatic set_cmd(input int inst, input int p, input logic [1:0] o,
                         input logic [2:0] t, input logic [15:0] d);
    if (inst == 0) begin
      valid[p] = 1'b1; op[2*p +: 2] = o; tree[3*p +: 3] = t; data[16*p +: 16] = d;
    end else begin
      f_valid[p] = 1'b1; f_op[2*p +: 2] = o; f_tree[3*p +: 3] = t; f_data[16*p +: 16] = d;
    end
  endtask

  task automatic expect_ev(input int inst, input int slot, input logic ps, input logic pp,
                           input logic [2:0] t, input logic [15:0] d, input int due);
    exp_t e;
    e.push = ps; e.pop = pp; e.tree = t; e.data = d; e.due = due;
    sb[inst*4 + slot].push_back(e);
  endtask

  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cyc %0d)", name, got, want, cyc);
    end
  endtask

  task automatic do_reset();
    step();
    rst = 1'b1;
    clear_cmds();
    busy = '0;
    step();
    rst = 1'b0;
  endtask

  // Scoreboard monitor: every strobe must match the queue head at its due cycle.
  always @(negedge clk) begin
    logic        ps, pp;
    logic [2:0]  tr;
    logic [15:0] dt;
    exp_t        e;
    int          q;
    for (int i = 0; i < 2; i++) begin
      for (int r = 0; r < 4; r++) begin
        q  = i*4 + r;
        ps = (i == 0) ? push[r] : f_push[r];
        pp = (i == 0) ? pop[r]  : f_pop[r];
        tr = (i == 0) ? rtree[3*r +: 3] : f_rtree[3*r +: 3];
        dt = (i == 0) ? rdata[16*r +: 16] : f_rdata[16*r +: 16];
        checks++;
        if (ps || pp) begin
          if (sb[q].size() == 0) begin
            errors++;
            $display("FAIL unexpected_strobe inst%0d slot%0d cyc %0d: push=%b pop=%b tree=%0d data=%h",
                     i, r, cyc, ps, pp, tr, dt);
          end else begin
            e = sb[q].pop_front();
            if (ps !== e.push || pp !== e.pop || tr !== e.tree || dt !== e.data || e.due != cyc) begin
              errors++;
              $display("FAIL strobe inst%0d slot%0d: got push=%b pop=%b tree=%0d data=%h cyc=%0d, expected push=%b pop=%b tree=%0d data=%h cyc=%0d",
                       i, r, ps, pp, tr, dt, cyc, e.push, e.pop, e.tree, e.data, e.due);
            end
          end
        end else begin
          if (tr !== 3'd0 || dt !== 16'hFFFF) begin
            errors++;
            $display("FAIL idle_outputs inst%0d slot%0d cyc %0d: tree=%0d data=%h expected 0/ffff", i, r, cyc, tr, dt);
          end
          if (sb[q].size() > 0 && sb[q][0].due < cyc) begin
            errors++;
            $display("FAIL missed_strobe inst%0d slot%0d: none at cyc %0d, expected data=%h", i, r, sb[q][0].due, sb[q][0].data);
            void'(sb[q].pop_front());
          end
        end
      end
    end
  end

  vec_t vecs [7];
  int   c0;

  initial begin
    clear_cmds();
    busy = '0;
    f_busy = '0;

    vecs[0] = '{0, 2'b01, 3'd2, 16'h1234, 2, 1, 1'b1, 1'b0, 16'h1234, 16'h0000, 1};
    vecs[1] = '{1, 2'b10, 3'd5, 16'hABCD, 1, 1, 1'b0, 1'b1, 16'hFFFF, 16'h0000, 1};
    vecs[2] = '{3, 2'b01, 3'd7, 16'hABCD, 3, 1, 1'b1, 1'b0, 16'hABCD, 16'h0000, 1};
    vecs[3] = '{2, 2'b00, 3'd1, 16'h5555, 1, 0, 1'b0, 1'b0, 16'hFFFF, 16'h0000, 0};
    vecs[4] = '{2, 2'b11, 3'd6, 16'h0F0F, 2, 2, 1'b0, 1'b1, 16'hFFFF, 16'h0F0F, 1};
    vecs[5] = '{1, 2'b01, 3'd0, 16'h0001, 0, 1, 1'b1, 1'b0, 16'h0001, 16'h0000, 1};
    vecs[6] = '{0, 2'b01, 3'd4, 16'h8000, 0, 1, 1'b1, 1'b0, 16'h8000, 16'h0000, 1};

    do_reset();
    for (int p = 0; p < 4; p++) begin
      chk($sformatf("reset_count_p%0d", p), int'(count[CW*p +: CW]), 0);
      chk($sformatf("reset_ready_p%0d", p), int'(ready[p]), 1);
    end

    // Single commands on an idle dispatcher.
    for (int i = 0; i < 7; i++) begin
      step();
      set_cmd(0, vecs[i].port, vecs[i].op, vecs[i].tree, vecs[i].data);
      if (vecs[i].e_n >= 1)
        expect_ev(0, vecs[i].e_slot, vecs[i].e_push1, vecs[i].e_pop1, vecs[i].tree, vecs[i].e_d1, cyc + 2);
      if (vecs[i].e_n == 2)
        expect_ev(0, vecs[i].e_slot, 1'b1, 1'b0, vecs[i].tree, vecs[i].e_d2, cyc + 3);
      step();
      clear_cmds();
      chk($sformatf("vec%0d_count", i), int'(count[CW*vecs[i].port +: CW]), vecs[i].e_cnt);
      repeat (4) step();
    end

    // Four ports hammering tree 1: rotation on RR instance, port-major on fixed priority.
    do_reset();
    step();
    c0 = cyc;
    for (int k = 0; k < 16; k++) begin
      expect_ev(0, 1, 1'b1, 1'b0, 3'd1, 16'h1100 + 16'((k % 4) * 16 + k / 4), c0 + 2 + k);
      expect_ev(1, 1, 1'b1, 1'b0, 3'd1, 16'h1100 + 16'((k / 4) * 16 + k % 4), c0 + 2 + k);
    end
    for (int j = 0; j < 4; j++) begin
      if (j > 0) step();
      for (int p = 0; p < 4; p++) begin
        set_cmd(0, p, 2'b01, 3'd1, 16'h1100 + 16'(p * 16 + j));
        set_cmd(1, p, 2'b01, 3'd1, 16'h1100 + 16'(p * 16 + j));
      end
    end
    step();
    clear_cmds();
    repeat (20) step();

    // Replace: pop then push, count drops only after the push.
    step();
    c0 = cyc;
    set_cmd(0, 2, 2'b11, 3'd3, 16'hBEEF);
    expect_ev(0, 3, 1'b0, 1'b1, 3'd3, 16'hFFFF, c0 + 2);
    expect_ev(0, 3, 1'b1, 1'b0, 3'd3, 16'hBEEF, c0 + 3);
    step();
    clear_cmds();
    step();
    chk("replace_count_after_pop", int'(count[CW*2 +: CW]), 1);
    step();
    chk("replace_count_after_push", int'(count[CW*2 +: CW]), 0);
    repeat (3) step();

    // Slot 0 busy for 5 cycles while port 1 waits, then RR pointer must sit at port 2.
    do_reset();
    step();
    c0 = cyc;
    busy = 4'b0001;
    set_cmd(0, 1, 2'b01, 3'd4, 16'h4444);
    expect_ev(0, 0, 1'b1, 1'b0, 3'd4, 16'h4444, c0 + 7);
    step();
    clear_cmds();
    repeat (4) step();
    chk("busy_head_held", int'(count[CW*1 +: CW]), 1);
    step();
    busy = '0;
    repeat (2) step();
    set_cmd(0, 0, 2'b01, 3'd0, 16'hAAAA);
    set_cmd(0, 2, 2'b01, 3'd4, 16'hBBBB);
    expect_ev(0, 0, 1'b1, 1'b0, 3'd4, 16'hBBBB, cyc + 2);
    expect_ev(0, 0, 1'b1, 1'b0, 3'd0, 16'hAAAA, cyc + 3);
    step();
    clear_cmds();
    repeat (5) step();

    // Fill port 0 against a blocked slot, then release it.
    do_reset();
    busy = 4'b0100;
    for (int j = 0; j < 8; j++) begin
      step();
      set_cmd(0, 0, 2'b01, 3'd2, 16'h2000 + 16'(j));
    end
    step();
    clear_cmds();
    chk("full_count", int'(count[CW*0 +: CW]), 8);
    chk("full_ready", int'(ready[0]), 0);
    set_cmd(0, 0, 2'b01, 3'd2, 16'h2999);
    step();
    clear_cmds();
    chk("ninth_rejected_count", int'(count[CW*0 +: CW]), 8);
    step();
    busy = '0;
    for (int j = 0; j < 8; j++) expect_ev(0, 2, 1'b1, 1'b0, 3'd2, 16'h2000 + 16'(j), cyc + 1 + j);
    chk("unblock_count_same_cycle", int'(count[CW*0 +: CW]), 8);
    step();
    chk("unblock_count_next", int'(count[CW*0 +: CW]), 7);
    chk("unblock_ready_next", int'(ready[0]), 1);
    repeat (10) step();

    // Reset between the pop and push halves of a replace.
    step();
    c0 = cyc;
    set_cmd(0, 3, 2'b11, 3'd3, 16'hBEEF);
    expect_ev(0, 3, 1'b0, 1'b1, 3'd3, 16'hFFFF, c0 + 2);
    step();
    clear_cmds();
    step();
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("rst_pop_idle", int'(pop[3]), 0);
    chk("rst_push_idle", int'(push[3]), 0);
    chk("rst_data_idle", int'(rdata[48 +: 16]), 32'hFFFF);
    step();
    rst = 1'b0;
    chk("rst_count", int'(count[CW*3 +: CW]), 0);
    chk("rst_ready", int'(ready), 32'hF);
    repeat (6) step();
    set_cmd(0, 3, 2'b01, 3'd3, 16'h5555);
    expect_ev(0, 3, 1'b1, 1'b0, 3'd3, 16'h5555, cyc + 2);
    step();
    clear_cmds();
    repeat (5) step();

    for (int q = 0; q < 8; q++) chk($sformatf("scoreboard_drained_%0d", q), sb[q].size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rpu_task_dispatch.md
# rpu_task_dispatch

Parametrised task front-end for the virtualised PIFO ring: buffers push/pop/replace commands from P ingress ports in per-port queues and dispatches them onto the LEVEL RPU injection slots of the SRAM PIFO ring. Each RPU slot has its own arbiter, and dispatch to a slot is held off while ring traffic occupies it. This block replaces the fixed one-queue-per-level task path with configurable port count, queue depth, arbitration mode and a combined push+pop (replace) command.

## Interface
- PTW, 16, payload width
- MTW, 0, metadata width; task data is MTW+PTW bits
- TREE_NUM, 4, number of virtual trees; TNB = $clog2(TREE_NUM)
- LEVEL, 4, RPU/slot count; power of 2, LEVEL <= TREE_NUM
- PORTS, 4, ingress port count
- DEPTH, 8, entries per port queue; power of 2, >= 2
- ARB_MODE, 0, 0 = round-robin per slot, 1 = fixed priority (lowest port wins)
- i_clk  in  1  clock
- i_arst  in  1  reset; one clock, asynchronous, active-high
- i_valid  in  [PORTS]  command valid per port
- o_ready  out  [PORTS]  port can accept a command
- i_op  in  2 x PORTS  per-port command: 01 push, 10 pop, 11 replace (pop then push), 00 nop
- i_tree_id  in  TNB x PORTS  target tree
- i_data  in  (MTW+PTW) x PORTS  push payload
- i_slot_busy  in  [LEVEL]  slot r's RPU input is taken by ring traffic next cycle
- o_rpu_push / o_rpu_pop  out  [LEVEL]  one-cycle injection strobes
- o_rpu_tree_id  out  TNB x LEVEL  tree of injected task
- o_rpu_data  out  (MTW+PTW) x LEVEL  push payload
- o_fifo_count  out  ($clog2(DEPTH)+1) x PORTS  queue occupancy

## Operation
- Accept on i_valid & o_ready. o_ready = (count < DEPTH) and depends only on count, so a full queue does not accept even while it dequeues. op 00 is accepted and discarded.
- A queue entry holds {op, tree_id, data}. The head's target slot is s = tree_id & (LEVEL-1).
- Per slot r, each cycle:
  - Candidates are non-empty port heads with s == r.
  - If i_slot_busy[r] is high, there is no grant.
  - Otherwise one winner per ARB_MODE.
  - Each head targets exactly one slot, so a port wins at most one slot per cycle.
- Round-robin: one pointer per slot, reset to 0. Port search starts at the pointer. After a grant the pointer becomes winner+1 mod PORTS. With no grant the pointer is unchanged.
- Grant effects:
  - push → o_rpu_push.
  - pop → o_rpu_pop; data all ones.
  - replace uses a per-port phase bit (reset 0). Phase 0 issues a pop and sets the phase bit; the head stays. Phase 1 issues a push with the data, clears the phase bit, and dequeues the head. Other ports may win the slot between the two phases.
- Idle slot outputs: push=0, pop=0, tree_id=0, data='1.
- Ordering: commands from one port dispatch strictly in order. No ordering is guaranteed across ports.

## Timing
- Command accepted at edge t is visible at the head from t+1. If granted in cycle t+1, its strobes are registered and high during cycle t+2. Minimum latency is 2 cycles; all outputs are registered.
- Replace takes at least 2 grant cycles. The pop strobe always precedes the push strobe.
- Sustained throughput is one task per slot per cycle. A port sustains 1 task/cycle when uncontended.
- Count arithmetic: enqueue and dequeue in the same cycle leave count unchanged. Pointers wrap modulo DEPTH; count never exceeds DEPTH.
- i_slot_busy is sampled in the grant cycle. A blocked head stays, and the RR pointer does not move.
- Reset (any time, including mid-replace):
  - Queues emptied; counts 0; o_ready all 1 after release.
  - Phase bits and RR pointers 0.
  - All strobes 0, tree_id 0, data '1.
  - In-progress replace halves are lost.

## Structure
- Package rpu_dispatch_pkg holds:
  - op enum (OP_NOP, OP_PUSH, OP_POP, OP_REPLACE);
  - task struct {op, tree_id, data}, parametrised via localparam widths;
  - slot_of(tree_id) function;
  - idle-data constant.
- Sub-module task_queue: synchronous FIFO (DEPTH, entry width) with count, full, empty, and head-visible read; instantiated per port.
- Arbiter per slot: generate loop in the top.

## Test plan
- Single push, port 0, tree 2, data 0x1234, LEVEL=4 → o_rpu_push[2]=1 with tree_id=2, data=0x1234 exactly 2 cycles after accept; all other slots idle.
- Ports 0–3 all push tree 1 every cycle, ARB_MODE=0 → slot 1 grants ports 0,1,2,3,0… one per cycle. With ARB_MODE=1, port 0 wins until its queue drains.
- Replace on tree 3, data 0xBEEF → o_rpu_pop[3] in cycle n, o_rpu_push[3] with 0xBEEF in cycle n+1; queue count drops by 1 only after the push.
- i_slot_busy[0] held high 5 cycles while port 1 pushes tree 4 → no slot-0 strobe during hold; the push is emitted 1 cycle after busy drops, and RR pointer movement is checked.
- DEPTH=8: 8 accepts with slot blocked → count 8, o_ready=0. A 9th valid is not accepted. Unblock → count decrements and ready returns the next cycle.
- Assert i_arst mid-replace (after pop phase) → outputs idle immediately; after release counts are 0, no push strobe appears, and a new command works normally.
